ps2_transmitter: RTL and testbench
==================================

# ps2_transmitter

Byte-to-serial PS/2 frame generator: the transmit-side counterpart of `PS2_Controller`. Accepts bytes into a small FIFO and shifts each out on a single data line as an 11-bit PS/2 frame. The frame is start 0, eight data bits LSB-first, odd parity, and stop 1. One bit advances per `en` strobe. `D` connects directly to a `PS2_Controller` `D` input for loopback testing, and drives a host-to-device data line in the keyboard path.

## Interface
Parameters
- DEPTH, 4: FIFO entries; power of two, ≥2.
- GAP, 1: extra idle-high bit times inserted after each stop bit; 0 = back-to-back frames.

Ports
- CLK  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  1  bit-time strobe; FSM and bit counter advance only on CLK edges with en=1.
- data  in  8  byte to enqueue.
- wr  in  1  push data into FIFO on this edge.
- full  out  1  FIFO holds DEPTH entries (registered).
- empty  out  1  FIFO holds 0 entries (registered).
- overflow  out  1  sticky; set when wr arrives while full.
- D  out  1  serial line, registered; idle high.
- busy  out  1  high from frame start to end of GAP.
- done  out  1  one-CLK pulse when a frame's stop bit completes.

## Operation
- FIFO: circular buffer with wrap-around pointers and a count of width clog2(DEPTH)+1.
  - wr && !full: push on this edge.
  - wr && full: byte dropped, overflow<=1. This holds even if a pop occurs on the same edge; full is sampled pre-edge.
  - A push and a pop on the same edge leave count unchanged.
- FSM states: IDLE, DATA, PARITY, STOP, GAP. Transitions happen only on en edges.
  - IDLE, en && !empty: pop head into the 8-bit shift register. Compute parity = ~^byte (total ones in data+parity is odd). D<=0 (start bit), bitcnt<=0, busy<=1, go to DATA.
  - DATA, en: D<=shift[0], shift>>=1, bitcnt++. After the 8th data bit is launched (bitcnt==7), go to PARITY.
  - PARITY, en: D<=parity, go to STOP.
  - STOP, en: D<=1, go to END. END is a sub-phase of STOP tracked by a flag, not a distinct encoded state.
  - STOP/END, en: the stop bit is complete and done<=1 for that cycle.
    - If GAP>0: go to GAP with gapcnt<=GAP-1.
    - If GAP==0 and !empty: perform the IDLE start action on this same edge.
    - Otherwise: go to IDLE, busy<=0.
  - GAP, en: D stays 1. When gapcnt==0, take the IDLE start action if !empty, else go to IDLE with busy<=0. Otherwise gapcnt--.
- Without en, the FSM, D and done hold. The FIFO still accepts writes.
- The FIFO changes only at CLK edges; a byte written during a frame waits its turn.

## Timing
- Reset values: D=1, busy=0, done=0, full=0, empty=1, overflow=0, FIFO pointers=0, state=IDLE.
- Reset asserted mid-frame: on the next edge D returns to 1, the frame is abandoned and the FIFO is flushed. No done pulse is issued.
- Each frame bit holds on D for exactly one en interval, starting on the CLK after the en edge that launched it.
- Frame cost: 12 en strobes from start-bit launch to done, plus GAP strobes of idle.
- With GAP=0 and en=1 every cycle, consecutive frames repeat every 11 cycles. The edge that pulses done also launches the next start bit.
- Latency: wr on edge n, FIFO empty, FSM in IDLE. The start bit appears after the first en edge at n+1 or later.
- done is high for exactly one CLK, never two consecutive cycles. It aligns with the edge that ends the stop bit.
- empty/full update on the same edge as the push/pop.

## Test plan
- Single byte: reset, push 0x1C, en every 4 CLKs. D must show 0,0,0,1,1,1,0,0,0,0,1, each bit 4 cycles wide. Then done pulses once, then busy=0 after one GAP bit.
- Parity: push 0x00 → parity bit 1; push 0xFF → 1; push 0x01 → 0.
- Loopback: D into `PS2_Controller` on a shared en. Send 0x1C, 0x32, 0xF0. The receiver must assert rdy three times with matching data bits and no parity error.
- Overflow: en=0, DEPTH=4, push 0xA1..0xA5. full=1 after the 4th push and overflow=1 after the 5th. With en enabled, exactly 0xA1..0xA4 are transmitted, in order.
- Back-to-back: GAP=0, en=1 constant, push 0x55 and 0xAA. Start bits at cycles t and t+11 with no idle bit between. done pulses at t+11 and t+22.
- Reset mid-frame: assert reset during the 4th data bit. Next cycle D=1, busy=0, empty=1. A subsequent push of 0x12 transmits a clean, correct frame.

Source files
------------

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: byte FIFO feeding an 11-bit PS/2 frame serializer.
// One frame bit advances per en strobe; D idles high.
module ps2_transmitter #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       D,
  output logic       busy,
  output logic       done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;

  state_t        state_q, state_d;
  logic          end_q, end_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0] gapcnt_q, gapcnt_d;
  logic          d_q, d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          push;
  logic          pop;
  logic          start;
  logic [7:0]    head;

  assign head = mem_q[rd_ptr_q];
  assign push = wr && !full_q;

  always_comb begin
    state_d  = state_q;
    end_d    = end_q;
    shift_d  = shift_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    d_d      = d_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    start    = 1'b0;
    pop      = 1'b0;

    if (en) begin
      unique case (state_q)
        S_IDLE: start = !empty_q;
        S_DATA: begin
          d_d      = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          d_d     = par_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (!end_q) begin
            d_d   = 1'b1;
            end_d = 1'b1;
          end else begin
            done_d = 1'b1;
            end_d  = 1'b0;
            if (GAP > 0) begin
              state_d  = S_GAP;
              gapcnt_d = GAP_INIT;
            end else if (!empty_q) begin
              start = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gapcnt_q == '0) begin
            if (!empty_q) begin
              start = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            gapcnt_d = gapcnt_q - GW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Start action is shared by IDLE, END (GAP=0) and GAP exit.
    if (start) begin
      pop      = 1'b1;
      shift_d  = head;
      par_d    = ~^head;
      d_d      = 1'b0;
      bitcnt_d = 3'd0;
      busy_d   = 1'b1;
      end_d    = 1'b0;
      state_d  = S_DATA;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CNT_FULL);
    empty_d  = (count_d == '0);
    ovf_d    = ovf_q || (wr && full_q);
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      end_q    <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      d_q      <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      end_q    <= end_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;
  assign D        = d_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: directed checks of frame shape, parity,
// FIFO overflow, back-to-back timing and mid-frame reset.
module tb_ps2_transmitter;

  logic       CLK = 1'b0;
  logic       reset;
  logic       en0, en1, wr0, wr1;
  logic [7:0] data0, data1;
  logic       full0, empty0, ovf0, D0, busy0, done0;
  logic       full1, empty1, ovf1, D1, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;
  logic last_par;

  always #5 CLK = ~CLK;

  ps2_transmitter #(.DEPTH(4), .GAP(1)) dut0 (
    .CLK(CLK), .reset(reset), .en(en0), .data(data0), .wr(wr0),
    .full(full0), .empty(empty0), .overflow(ovf0),
    .D(D0), .busy(busy0), .done(done0)
  );

  ps2_transmitter #(.DEPTH(4), .GAP(0)) dut1 (
    .CLK(CLK), .reset(reset), .en(en1), .data(data1), .wr(wr1),
    .full(full1), .empty(empty1), .overflow(ovf1),
    .D(D1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic push0(input logic [7:0] b);
    wr0 = 1'b1;
    data0 = b;
    @(negedge CLK);
    wr0 = 1'b0;
  endtask

  task automatic push1(input logic [7:0] b);
    wr1 = 1'b1;
    data1 = b;
    @(negedge CLK);
    wr1 = 1'b0;
  endtask

  // exp[i] is frame bit i in time order; en strobes every p CLKs.
  task automatic run_frame(input string tag, input logic [10:0] exp,
                           input int p);
    for (int i = 0; i < 11; i++) begin
      en0 = 1'b1;
      for (int j = 0; j < p; j++) begin
        @(negedge CLK);
        en0 = 1'b0;
        if (j == 0 || j == p - 1)
          chk($sformatf("%s_bit%0d", tag, i), D0, exp[i]);
        if (j == 0 && i == 10) chk({tag, "_nodone"}, done0, 1'b0);
      end
      if (i == 9) last_par = D0;
    end
    en0 = 1'b1;
    @(negedge CLK);
    en0 = 1'b0;
    chk({tag, "_done"}, done0, 1'b1);
    chk({tag, "_busy"}, busy0, 1'b1);
    @(negedge CLK);
    chk({tag, "_done1"}, done0, 1'b0);
  endtask

  task automatic idle_strobe(input string tag);
    en0 = 1'b1;
    @(negedge CLK);
    en0 = 1'b0;
    chk({tag, "_idle_busy"}, busy0, 1'b0);
    chk({tag, "_idle_d"}, D0, 1'b1);
  endtask

  initial begin
    logic [24:0] dseq, dnseq, exp_d, exp_dn;
    logic [10:0] f55, faa;

    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0;
    data0 = '0; data1 = '0;
    repeat (2) @(negedge CLK);
    chk("rst_d", D0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_full", full0, 1'b0);
    chk("rst_empty", empty0, 1'b1);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_d1", D1, 1'b1);
    reset = 1'b0;
    @(negedge CLK);

    push0(8'h1C);
    chk("push_empty", empty0, 1'b0);
    run_frame("b1c", 11'b10000111000, 4);
    chk("b1c_gap_busy", busy0, 1'b1);
    idle_strobe("b1c");
    chk("b1c_empty", empty0, 1'b1);

    push0(8'h00);
    push0(8'hFF);
    push0(8'h01);
    run_frame("p00", frame_of(8'h00), 2);
    chk("par00", last_par, 1'b1);
    run_frame("pff", frame_of(8'hFF), 2);
    chk("parff", last_par, 1'b1);
    run_frame("p01", frame_of(8'h01), 2);
    chk("par01", last_par, 1'b0);
    idle_strobe("par");

    for (int k = 0; k < 5; k++) begin
      push0(8'hA1 + 8'(k));
      if (k == 3) begin
        chk("ovf_full4", full0, 1'b1);
        chk("ovf_none4", ovf0, 1'b0);
      end
      if (k == 4) begin
        chk("ovf_set5", ovf0, 1'b1);
        chk("ovf_full5", full0, 1'b1);
      end
    end
    run_frame("a1", frame_of(8'hA1), 1);
    chk("ovf_notfull", full0, 1'b0);
    run_frame("a2", frame_of(8'hA2), 1);
    run_frame("a3", frame_of(8'hA3), 1);
    run_frame("a4", frame_of(8'hA4), 1);
    idle_strobe("ovf");
    chk("ovf_empty", empty0, 1'b1);
    chk("ovf_sticky", ovf0, 1'b1);

    push1(8'h55);
    push1(8'hAA);
    f55 = frame_of(8'h55);
    faa = frame_of(8'hAA);
    exp_d = '1;
    exp_dn = '0;
    for (int i = 0; i < 11; i++) begin
      exp_d[1 + i]  = f55[i];
      exp_d[12 + i] = faa[i];
    end
    exp_dn[12] = 1'b1;
    exp_dn[23] = 1'b1;
    dseq = '1;
    dnseq = '0;
    en1 = 1'b1;
    for (int s = 1; s <= 24; s++) begin
      @(negedge CLK);
      dseq[s]  = D1;
      dnseq[s] = done1;
    end
    en1 = 1'b0;
    chk("b2b_d", 32'(dseq), 32'(exp_d));
    chk("b2b_done", 32'(dnseq), 32'(exp_dn));
    chk("b2b_busy", busy1, 1'b0);

    push0(8'h3C);
    push0(8'h5A);
    for (int k = 0; k < 5; k++) begin
      en0 = 1'b1;
      @(negedge CLK);
      en0 = 1'b0;
      @(negedge CLK);
    end
    chk("mid_bit3", D0, 1'b1);
    chk("mid_busy", busy0, 1'b1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("mrst_d", D0, 1'b1);
    chk("mrst_busy", busy0, 1'b0);
    chk("mrst_empty", empty0, 1'b1);
    chk("mrst_done", done0, 1'b0);
    chk("mrst_ovf", ovf0, 1'b0);
    push0(8'h12);
    run_frame("r12", frame_of(8'h12), 2);
    idle_strobe("r12");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
